// File: rtl/motor_pkg.sv
// Shared motor-control types and constants used by the gate dead-time inserter.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DEAD = 2'd3
    } phase_state_t;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2
    } phase_req_t;

    localparam int K_NPHASES = 3;

    // All low sides on: shorts the motor windings for braking.
    localparam logic [2*K_NPHASES-1:0] K_BRAKE_PATTERN = 6'b000111;

endpackage

// File: rtl/deadtime_phase.sv
// One half-bridge leg: request decode, HI/LO/DEAD state machine, dead-time counter,
// last-side memory and sticky illegal-request flag.
module deadtime_phase
    import motor_pkg::*;
#(
    parameter int K_DT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_hi,
    input  logic              i_lo,
    input  logic [K_DT_W-1:0] i_deadtime,
    input  logic              i_fault_clear,
    output logic              o_gate_hi,
    output logic              o_gate_lo,
    output logic              o_dead_active,
    output logic              o_fault
);

    phase_state_t      state_q, state_d;
    phase_state_t      last_q, last_d;
    logic [K_DT_W-1:0] cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic              gate_hi_q, gate_hi_d;
    logic              gate_lo_q, gate_lo_d;
    logic              dead_active_q, dead_active_d;
    phase_req_t        req_s;
    logic              same_side_s;
    logic              other_side_s;

    // State register: all flops of the leg.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            last_q        <= IDLE;
            cnt_q         <= '0;
            fault_q       <= 1'b0;
            gate_hi_q     <= 1'b0;
            gate_lo_q     <= 1'b0;
            dead_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            fault_q       <= fault_d;
            gate_hi_q     <= gate_hi_d;
            gate_lo_q     <= gate_lo_d;
            dead_active_q <= dead_active_d;
        end
    end

    // Next state: decode the request (both sides set counts as OFF) and step the leg.
    always_comb begin
        case ({i_hi, i_lo})
            2'b10:   req_s = REQ_HI;
            2'b01:   req_s = REQ_LO;
            default: req_s = REQ_OFF;
        endcase
        same_side_s  = ((req_s == REQ_HI) && (last_q == HI)) || ((req_s == REQ_LO) && (last_q == LO));
        other_side_s = ((req_s == REQ_HI) && (last_q == LO)) || ((req_s == REQ_LO) && (last_q == HI));
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_enable && (req_s == REQ_HI)) begin
                    state_d = HI;
                end else if (i_enable && (req_s == REQ_LO)) begin
                    state_d = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            HI, LO: begin
                if (!i_enable || (req_s != ((state_q == HI) ? REQ_HI : REQ_LO))) begin
                    state_d = DEAD;
                    cnt_d   = i_deadtime;
                    last_d  = state_q;
                end else begin
                    state_d = state_q;
                end
            end
            DEAD: begin
                // Returning to the side just left never risks shoot-through.
                if (i_enable && same_side_s) begin
                    state_d = last_q;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - {{(K_DT_W-1){1'b0}}, 1'b1};
                end else if (i_enable && other_side_s) begin
                    state_d = (last_q == HI) ? LO : HI;
                end else begin
                    state_d = DEAD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                last_d  = IDLE;
            end
        endcase
        if (i_hi && i_lo) begin
            fault_d = 1'b1;
        end else if (i_fault_clear) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // Outputs: registered decode of the next state so gates follow state without extra delay.
    always_comb begin
        gate_hi_d     = i_enable && (state_d == HI);
        gate_lo_d     = i_enable && (state_d == LO);
        dead_active_d = (state_d == DEAD) && (cnt_d != '0);
    end

    assign o_gate_hi     = gate_hi_q;
    assign o_gate_lo     = gate_lo_q;
    assign o_dead_active = dead_active_q;
    assign o_fault       = fault_q;

endmodule

// File: rtl/gate_deadtime_inserter.sv
// Converts the 6-step commutation pattern into half-bridge gate commands with
// programmable dead time; one independent deadtime_phase per leg.
module gate_deadtime_inserter #(
    parameter int K_DT_W    = 8,
    parameter int K_NPHASES = motor_pkg::K_NPHASES
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [2*K_NPHASES-1:0] i_pattern,
    input  logic [K_DT_W-1:0]      i_deadtime,
    input  logic                   i_fault_clear,
    output logic [2*K_NPHASES-1:0] o_gate,
    output logic [K_NPHASES-1:0]   o_dead_active,
    output logic [K_NPHASES-1:0]   o_fault
);

    logic [K_NPHASES-1:0] gate_hi_s;
    logic [K_NPHASES-1:0] gate_lo_s;

    for (genvar p = 0; p < K_NPHASES; p++) begin : g_phase
        deadtime_phase #(
            .K_DT_W(K_DT_W)
        ) u_phase (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_enable     (i_enable),
            .i_hi         (i_pattern[K_NPHASES+p]),
            .i_lo         (i_pattern[p]),
            .i_deadtime   (i_deadtime),
            .i_fault_clear(i_fault_clear),
            .o_gate_hi    (gate_hi_s[p]),
            .o_gate_lo    (gate_lo_s[p]),
            .o_dead_active(o_dead_active[p]),
            .o_fault      (o_fault[p])
        );
    end

    assign o_gate = {gate_hi_s, gate_lo_s};

endmodule

// File: tb/tb_gate_deadtime_inserter.sv
// Randomized and directed bench for gate_deadtime_inserter against a per-leg
// timing model (conducting side, last side, cycles spent off).
module tb_gate_deadtime_inserter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [5:0] pattern;
    logic [7:0] deadtime;
    logic       fault_clear;
    logic [5:0] gate;
    logic [2:0] dead_active;
    logic [2:0] fault;

    int checks   = 0;
    int failures = 0;

    // Model: cur/last side 0=none 1=high 2=low; offc = edges since turn-off; need = dt+1.
    int         cur  [3];
    int         last [3];
    int         offc [3];
    int         need [3];
    logic [2:0] fault_m;

    gate_deadtime_inserter #(.K_DT_W(8), .K_NPHASES(3)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_pattern    (pattern),
        .i_deadtime   (deadtime),
        .i_fault_clear(fault_clear),
        .o_gate       (gate),
        .o_dead_active(dead_active),
        .o_fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            cur[p] = 0; last[p] = 0; offc[p] = 0; need[p] = 0;
        end
        fault_m = 3'b000;
    endtask

    task automatic model_edge(input logic [5:0] pat, input logic en, input logic [7:0] dt, input logic clr);
        for (int p = 0; p < 3; p++) begin
            logic hi, lo;
            int   r;
            hi = pat[3+p];
            lo = pat[p];
            r  = (hi && !lo) ? 1 : ((lo && !hi) ? 2 : 0);
            if (hi && lo) fault_m[p] = 1'b1;
            else if (clr) fault_m[p] = 1'b0;
            if (cur[p] != 0) begin
                if (!(en && r == cur[p])) begin
                    last[p] = cur[p]; cur[p] = 0; need[p] = int'(dt) + 1; offc[p] = 1;
                end
            end else if (last[p] == 0) begin
                if (en && r != 0) cur[p] = r;
            end else if (en && r == last[p]) begin
                cur[p] = r;
            end else if (en && r != 0 && offc[p] >= need[p]) begin
                cur[p] = r;
            end else begin
                offc[p]++;
            end
        end
    endtask

    task automatic compare_all();
        logic [5:0] eg;
        logic [2:0] ed;
        for (int p = 0; p < 3; p++) begin
            eg[3+p] = (cur[p] == 1);
            eg[p]   = (cur[p] == 2);
            ed[p]   = (cur[p] == 0) && (last[p] != 0) && (offc[p] < need[p]);
        end
        chk("gate", 32'(gate), 32'(eg));
        chk("dead_active", 32'(dead_active), 32'(ed));
        chk("fault", 32'(fault), 32'(fault_m));
        chk("shoot_through", 32'(|(gate[5:3] & gate[2:0])), 32'd0);
    endtask

    task automatic step(input logic [5:0] pat, input logic en, input logic [7:0] dt, input logic clr);
        pattern = pat; enable = en; deadtime = dt; fault_clear = clr;
        @(posedge clk);
        model_edge(pat, en, dt, clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("reset_gate", 32'(gate), 32'd0);
        chk("reset_dead", 32'(dead_active), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] pat;
        logic       en;
        logic [7:0] dt;
        logic       clr;
        rst_n = 1'b1; enable = 1'b0; pattern = 6'b0; deadtime = 8'd0; fault_clear = 1'b0;
        #2;
        do_reset();
        @(negedge clk);

        // From IDLE: no dead time, one cycle latency.
        step(6'b001100, 1'b1, 8'd4, 1'b0);
        chk("idle_to_on", 32'(gate), 32'h0C);
        step(6'b010100, 1'b1, 8'd4, 1'b0);
        chk("a_off_b_on", 32'(gate), 32'h14);

        // A HI -> LO with dead time 3.
        step(6'b001000, 1'b1, 8'd3, 1'b0);
        step(6'b001000, 1'b1, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) step(6'b000001, 1'b1, 8'd3, 1'b0);
        chk("a_low_held_off", 32'(gate[0]), 32'd0);
        step(6'b000001, 1'b1, 8'd3, 1'b0);
        chk("a_low_rises", 32'(gate[0]), 32'd1);

        // B with zero dead time, both directions.
        for (int i = 0; i < 3; i++) step(6'b010000, 1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(6'b000010, 1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(6'b010000, 1'b1, 8'd0, 1'b0);

        // Illegal request on A and sticky fault.
        step(6'b001001, 1'b1, 8'd4, 1'b0);
        chk("illegal_fault", 32'(fault[0]), 32'd1);
        chk("illegal_gates_off", 32'({gate[3], gate[0]}), 32'd0);
        step(6'b000000, 1'b1, 8'd4, 1'b0);
        chk("fault_sticky", 32'(fault[0]), 32'd1);
        step(6'b000000, 1'b1, 8'd4, 1'b1);
        chk("fault_cleared", 32'(fault), 32'd0);

        // Disable with A HI, re-enable requesting A LO.
        for (int i = 0; i < 3; i++) step(6'b001000, 1'b1, 8'd5, 1'b0);
        step(6'b001000, 1'b0, 8'd5, 1'b0);
        chk("disabled_off", 32'(gate), 32'd0);
        step(6'b001000, 1'b0, 8'd5, 1'b0);
        for (int i = 0; i < 3; i++) step(6'b000001, 1'b1, 8'd5, 1'b0);
        chk("reenable_still_dead", 32'(gate[0]), 32'd0);
        step(6'b000001, 1'b1, 8'd5, 1'b0);
        step(6'b000001, 1'b1, 8'd5, 1'b0);
        chk("reenable_low_on", 32'(gate[0]), 32'd1);

        // Brake from a high-side state.
        for (int i = 0; i < 3; i++) step(6'b100001, 1'b1, 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) step(motor_pkg::K_BRAKE_PATTERN, 1'b1, 8'd2, 1'b0);

        // Randomized traffic with occasional resets mid-count.
        pat = 6'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                for (int p = 0; p < 3; p++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r == 0)     begin pat[3+p] = 1'b1; pat[p] = 1'b1; end
                    else if (r < 4) begin pat[3+p] = 1'b0; pat[p] = 1'b0; end
                    else if (r < 7) begin pat[3+p] = 1'b1; pat[p] = 1'b0; end
                    else            begin pat[3+p] = 1'b0; pat[p] = 1'b1; end
                end
            end
            en  = ($urandom_range(0, 15) != 0);
            dt  = 8'($urandom_range(0, 6));
            clr = ($urandom_range(0, 7) == 0);
            step(pat, en, dt, clr);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_deadtime_inserter.md
Name: gate_deadtime_inserter

Overview:
- Sits directly downstream of the 6-step commutation pattern generator, between its registered 6-bit pattern and the external half-bridge gate drivers.
- Per phase, turns requested high/low switch states into gate commands with programmable dead time, so both switches of a leg are never on together.
- Detects illegal requests that would cause shoot-through and reports them as a sticky fault.
- Adds one cycle of latency when no dead time is needed.

Parameters:
- K_DT_W, 8: width of the dead-time value and of each per-phase dead-time counter.
- K_NPHASES, 3: number of half-bridge legs; the pattern width is 2*K_NPHASES.

Ports:
- i_clk  in  1  main clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  output enable; low forces all gates off.
- i_pattern  in  2*K_NPHASES  requested switch states: bits [2*K_NPHASES-1:K_NPHASES] are high sides, bits [K_NPHASES-1:0] are low sides, bit index = phase.
- i_deadtime  in  K_DT_W  dead time in clock cycles.
- i_fault_clear  in  1  clears sticky fault bits.
- o_gate  out  2*K_NPHASES  gate commands, same bit layout as i_pattern, registered.
- o_dead_active  out  K_NPHASES  phase is in DEAD with counter non-zero.
- o_fault  out  K_NPHASES  sticky per-phase illegal-request flag.

Behaviour:
- Reset:
  - all phases go to IDLE with no last side recorded.
  - o_gate = 0, o_dead_active = 0, o_fault = 0, counters = 0.
- Per-phase request decoding: hi = i_pattern[K_NPHASES+p], lo = i_pattern[p].
  - req = HI, LO or OFF.
  - hi and lo both set (ILLEGAL) is treated as OFF and sets o_fault[p] on the next edge.
- States: IDLE, HI, LO, DEAD.
- Transitions, evaluated each edge when i_enable = 1:
  - IDLE: req HI goes to HI, req LO goes to LO, otherwise stay. No dead time from IDLE.
  - HI or LO, same req: stay.
  - HI or LO, any other req: go to DEAD, load counter with i_deadtime, record the last side. The gate turns off on this edge; turn-off is never delayed.
  - DEAD, counter > 0: decrement.
  - DEAD, req equals the last side: re-enter that state immediately, regardless of counter.
  - DEAD, req is the opposite side and counter = 0: enter that state.
  - DEAD, req OFF: stay, with the counter saturating at 0.
- Resulting timing:
  - HI to LO (or LO to HI) gives exactly i_deadtime+1 cycles with both gates of that leg at 0.
  - i_deadtime = 0 still gives 1 cycle of both-off.
- o_gate[hi side] = 1 only in HI; o_gate[lo side] = 1 only in LO. Outputs are registered and follow state with no extra delay (1-cycle pattern-to-gate latency).
- i_deadtime is sampled only on entry to DEAD. Changing it mid-count does not affect the running count.
- i_enable = 0:
  - next edge: o_gate = 0.
  - each HI/LO phase enters DEAD with the counter loaded and last side recorded. IDLE and DEAD phases hold; their counters keep running.
  - re-enabling therefore still honours the dead time.
- Brake pattern 000111 applied from a high-side-on state: that high side drops on the first edge, and its low side rises after i_deadtime+1 off cycles. Phases already LO or IDLE switch on without delay.
- Fault:
  - o_fault[p] is set by an ILLEGAL request and stays set until i_fault_clear.
  - set has priority over clear in the same cycle.
  - a fault does not stop operation; the illegal request behaves as OFF.
- Phases are fully independent. Simultaneous transitions on different phases never interact.
- Reset mid-count: gates go 0 asynchronously and the last-side history is lost (IDLE).

Decomposition:
- Shared package motor_pkg:
  - phase_state_t enum {IDLE, HI, LO, DEAD}.
  - phase_req_t enum {REQ_OFF, REQ_HI, REQ_LO}.
  - K_NPHASES = 3.
  - the brake pattern constant 6'b000111.
- Sub-module deadtime_phase:
  - one leg: FSM, counter, last side, fault bit.
  - instantiated K_NPHASES times by a generate loop in the top level.
  - the top level only slices the pattern and concatenates the outputs.

Test Plan:
- Reset, i_enable=1, i_deadtime=4, i_pattern=001100 -> next edge o_gate=001100; no DEAD entered (from IDLE).
- From 001100, apply 010100 (phase A HI->OFF, phase B OFF->HI, C LO held) -> A high drops next edge; B high rises next edge (B from IDLE); C low held throughout.
- Phase A HI, i_deadtime=3, request A LO (000001 plus others off) -> A high 0 next edge, A low stays 0 for 4 cycles, then 1; o_dead_active[0]=1 for 3 cycles.
- i_deadtime=0 HI->LO on phase B -> exactly 1 cycle with both B gates 0; an immediate LO->HI back -> again 1 off cycle.
- i_pattern=001001 (A high+low) -> o_gate A bits 0, o_fault[0]=1 and sticky; pulse i_fault_clear with a legal pattern -> o_fault=0.
- Phase A HI, deassert i_enable 2 cycles, re-enable requesting A LO with i_deadtime=5 -> o_gate=0 while disabled; A low rises 6 cycles after disable, not on re-enable.
